// File: rtl/pll_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pll_ctrl_pkg                                                 |
// | Description : Shared definitions for the PLL loop controller: default code |
// |               widths, FSM state encoding and a clamping adder.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pll_ctrl_pkg;

  localparam int DEF_CW = 8;
  localparam int DEF_FW = 8;
  localparam int DEF_IW = 12;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_C_CHK    = 2'd1;
  localparam logic [1:0] ST_C_SETTLE = 2'd2;
  localparam logic [1:0] ST_FINE     = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    C_CHK    = ST_C_CHK,
    C_SETTLE = ST_C_SETTLE,
    FINE     = ST_FINE
  } state_t;

  // a + b clamped into [lo, hi]; operands are small enough that int never overflows
  function automatic int sat_add(input int a, input int b, input int lo, input int hi);
    int s;
    s = a + b;
    if (s < lo) begin
      s = lo;
    end else if (s > hi) begin
      s = hi;
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pll_sync2                                                    |
// | Description : Two-flop synchronizer for one asynchronous input bit.        |
// | Ports       : clk   - destination clock                                    |
// |               rst   - async active-high reset (output clears to 0)         |
// |               d_i   - asynchronous input                                   |
// |               q_o   - synchronized output, two clk cycles of latency       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pll_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_loop_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pll_loop_ctrl                                                |
// | Description : PLL digital loop controller in the ref_clk domain. A SAR     |
// |               search sets the DCO band (coarse) code from PFD frequency    |
// |               checks, then a PI loop filter on the synchronized up/down    |
// |               pulses drives the DCO fine code.                             |
// | Option      : PLL_LOOP_LOCK_DET_EN - builds the lock detector; when not    |
// |               defined, lock is tied low.                                   |
// | Ports       : ref_clk, rst (async, active-high), recal (sync restart)      |
// |               up/down, ref_clk_is_faster/slower, freq_check_done,          |
// |               calibration_done - asynchronous PFD signals                  |
// |               coarse_code[CW], fine_code[FW] - DCO codes                   |
// |               dco_update - one-cycle pulse when a code changed             |
// |               lock, cal_timeout (sticky), state[2] (debug)                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pll_loop_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int CW         = DEF_CW,
  parameter int FW         = DEF_FW,
  parameter int IW         = DEF_IW,
  parameter int FRAC       = 4,
  parameter int KP         = 2,
  parameter int KI         = 1,
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_CNT = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic          ref_clk,
  input  logic          rst,
  input  logic          recal,
  input  logic          up,
  input  logic          down,
  input  logic          ref_clk_is_faster,
  input  logic          ref_clk_is_slower,
  input  logic          freq_check_done,
  input  logic          calibration_done,
  output logic [CW-1:0] coarse_code,
  output logic [FW-1:0] fine_code,
  output logic          dco_update,
  output logic          lock,
  output logic          cal_timeout,
  output logic [1:0]    state
);

  localparam int BIW = (CW > 1) ? $clog2(CW) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] COARSE_MID = CW'(1) << (CW - 1);
  localparam logic [FW-1:0] FINE_MID   = FW'(1) << (FW - 1);
  localparam int INTEG_MAX = 2 ** (IW - 1) - 1;
  localparam int INTEG_MIN = -(2 ** (IW - 1));
  localparam int FINE_MAX  = 2 ** FW - 1;

  // ---------------- input synchronization ----------------
  logic [5:0] async_in;
  logic [5:0] sync_out;

  assign async_in = {calibration_done, freq_check_done, ref_clk_is_slower,
                     ref_clk_is_faster, down, up};

  for (genvar gi = 0; gi < 6; gi++) begin : g_sync
    pll_sync2 u_sync (
      .clk (ref_clk),
      .rst (rst),
      .d_i (async_in[gi]),
      .q_o (sync_out[gi])
    );
  end

  logic up_s, down_s, faster_s, slower_s, chk_s, cal_s;
  assign up_s     = sync_out[0];
  assign down_s   = sync_out[1];
  assign faster_s = sync_out[2];
  assign slower_s = sync_out[3];
  assign chk_s    = sync_out[4];
  assign cal_s    = sync_out[5];

  // Edge history is only cleared by rst: clearing it on recal would turn a
  // strobe that is still high into a spurious edge.
  logic chk_prev_q, cal_prev_q;
  logic chk_edge, cal_edge;

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      chk_prev_q <= 1'b0;
      cal_prev_q <= 1'b0;
    end else begin
      chk_prev_q <= chk_s;
      cal_prev_q <= cal_s;
    end
  end

  assign chk_edge = chk_s & ~chk_prev_q;
  assign cal_edge = cal_s & ~cal_prev_q;

  // ---------------- control FSM and loop filter ----------------
  state_t                state_q, state_d;
  logic [CW-1:0]         coarse_q, coarse_d;
  logic [FW-1:0]         fine_q, fine_d;
  logic signed [IW-1:0]  integ_q, integ_d;
  logic [BIW-1:0]        bit_idx_q, bit_idx_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  cal_to_q, cal_to_d;
  logic                  dco_upd_q, dco_upd_d;
  int                    e_i;

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      coarse_q  <= COARSE_MID;
      fine_q    <= FINE_MID;
      integ_q   <= '0;
      bit_idx_q <= BIW'(CW - 1);
      tmr_q     <= '0;
      cal_to_q  <= 1'b0;
      dco_upd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      coarse_q  <= coarse_d;
      fine_q    <= fine_d;
      integ_q   <= integ_d;
      bit_idx_q <= bit_idx_d;
      tmr_q     <= tmr_d;
      cal_to_q  <= cal_to_d;
      dco_upd_q <= dco_upd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    coarse_d  = coarse_q;
    fine_d    = fine_q;
    integ_d   = integ_q;
    bit_idx_d = bit_idx_q;
    tmr_d     = '0;
    cal_to_d  = cal_to_q;
    e_i       = int'(up_s) - int'(down_s);

    unique case (state_q)
      IDLE: begin
        coarse_d  = COARSE_MID;
        bit_idx_d = BIW'(CW - 1);
        state_d   = C_CHK;
      end
      C_CHK: begin
        tmr_d = tmr_q + 1'b1;
        if (chk_edge) begin
          tmr_d = '0;
          if (faster_s != slower_s) begin
            // The trial bit is already set; only a "slower" verdict clears it.
            if (slower_s) coarse_d[bit_idx_q] = 1'b0;
            if (bit_idx_q == '0) begin
              state_d = FINE;
            end else begin
              coarse_d[bit_idx_q - 1'b1] = 1'b1;
              bit_idx_d = bit_idx_q - 1'b1;
              state_d   = C_SETTLE;
            end
          end else begin
            // Inconclusive check: keep the current trial code and go fine.
            state_d = FINE;
          end
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          cal_to_d = 1'b1;
          state_d  = FINE;
        end
      end
      C_SETTLE: begin
        tmr_d = tmr_q + 1'b1;
        if (cal_edge) begin
          tmr_d   = '0;
          state_d = C_CHK;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          cal_to_d = 1'b1;
          state_d  = FINE;
        end
      end
      FINE: begin
        integ_d = IW'(sat_add(int'(integ_q), e_i * KI, INTEG_MIN, INTEG_MAX));
        // Uses the freshly updated integrator so the fine code tracks this cycle's error.
        fine_d  = FW'(sat_add(int'(FINE_MID) + (int'(integ_d) >>> FRAC), e_i * KP, 0, FINE_MAX));
      end
      default: state_d = IDLE;
    endcase

    if (recal) begin
      state_d   = IDLE;
      coarse_d  = COARSE_MID;
      fine_d    = FINE_MID;
      integ_d   = '0;
      bit_idx_d = BIW'(CW - 1);
      tmr_d     = '0;
      cal_to_d  = 1'b0;
    end

    dco_upd_d = !recal && ((coarse_d != coarse_q) || (fine_d != fine_q));
  end

  assign coarse_code = coarse_q;
  assign fine_code   = fine_q;
  assign dco_update  = dco_upd_q;
  assign cal_timeout = cal_to_q;
  assign state       = state_q;

  // ---------------- lock detector ----------------
`ifdef PLL_LOOP_LOCK_DET_EN
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  logic [LW-1:0] zcnt_q, zcnt_d;
  logic [UW-1:0] nzcnt_q, nzcnt_d;
  logic          lock_q, lock_d;

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      zcnt_q  <= '0;
      nzcnt_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      zcnt_q  <= zcnt_d;
      nzcnt_q <= nzcnt_d;
      lock_q  <= lock_d;
    end
  end

  // Run-length counters saturate one short of their threshold; the threshold
  // cycle itself flips lock.
  always_comb begin
    zcnt_d  = zcnt_q;
    nzcnt_d = nzcnt_q;
    lock_d  = lock_q;
    if (recal || (state_q != FINE)) begin
      zcnt_d  = '0;
      nzcnt_d = '0;
      lock_d  = 1'b0;
    end else if (up_s == down_s) begin
      nzcnt_d = '0;
      if (zcnt_q >= LW'(LOCK_CNT - 1)) lock_d = 1'b1;
      else                             zcnt_d = zcnt_q + 1'b1;
    end else begin
      zcnt_d = '0;
      if (nzcnt_q >= UW'(UNLOCK_CNT - 1)) lock_d = 1'b0;
      else                                nzcnt_d = nzcnt_q + 1'b1;
    end
  end

  assign lock = lock_q;
`else
  logic unused_lock_cfg;
  assign unused_lock_cfg = (LOCK_CNT != UNLOCK_CNT);
  assign lock = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_loop_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pll_loop_ctrl                                             |
// | Description : Self-checking bench for pll_loop_ctrl. A small-parameter     |
// |               instance is exercised through SAR, timeout, recal and fine   |
// |               loop sequences against a behavioural model; a default-       |
// |               parameter instance is checked for reset values.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pll_loop_ctrl;

  localparam int CW = 4, FW = 6, IW = 12, FRAC = 2, KP = 2, KI = 1;
  localparam int LOCK_CNT = 16, UNLOCK_CNT = 4, TIMEOUT = 32;
  localparam int S_IDLE = 0, S_CHK = 1, S_SETTLE = 2, S_FINE = 3;
`ifdef PLL_LOOP_LOCK_DET_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, recal, up, down, faster, slower, fchk, cdone;
  logic [CW-1:0] coarse;
  logic [FW-1:0] fine;
  logic dco, lock, cto;
  logic [1:0] st;
  logic [7:0] d_coarse, d_fine;
  logic d_dco, d_lock, d_cto;
  logic [1:0] d_st;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pll_loop_ctrl #(
    .CW(CW), .FW(FW), .IW(IW), .FRAC(FRAC), .KP(KP), .KI(KI),
    .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .ref_clk(clk), .rst(rst), .recal(recal), .up(up), .down(down),
    .ref_clk_is_faster(faster), .ref_clk_is_slower(slower),
    .freq_check_done(fchk), .calibration_done(cdone),
    .coarse_code(coarse), .fine_code(fine), .dco_update(dco),
    .lock(lock), .cal_timeout(cto), .state(st)
  );

  pll_loop_ctrl dut_def (
    .ref_clk(clk), .rst(rst), .recal(recal), .up(up), .down(down),
    .ref_clk_is_faster(faster), .ref_clk_is_slower(slower),
    .freq_check_done(fchk), .calibration_done(cdone),
    .coarse_code(d_coarse), .fine_code(d_fine), .dco_update(d_dco),
    .lock(d_lock), .cal_timeout(d_cto), .state(d_st)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- SAR reference model ----------------
  // Code = bits already decided + the trial bit of the next undecided position.
  int  m_k, m_acc, m_code;
  bit  m_done;

  function automatic void sar_reset();
    m_k = 0; m_acc = 0; m_code = 2 ** (CW - 1); m_done = 1'b0;
  endfunction

  function automatic void sar_decide(input bit f, input bit s);
    if (f == s) begin
      m_done = 1'b1;
    end else begin
      if (f) m_acc += 2 ** (CW - 1 - m_k);
      m_k++;
      if (m_k == CW) m_done = 1'b1;
      m_code = m_acc + ((m_k < CW) ? 2 ** (CW - 1 - m_k) : 0);
    end
  endfunction

  // PFD strobes cross two sync flops plus one edge-detect cycle.
  task automatic do_check(input bit f, input bit s);
    faster = f; slower = s; fchk = 1'b1;
    tick();
    fchk = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_settle();
    cdone = 1'b1;
    tick();
    cdone = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_recal();
    recal = 1'b1;
    tick();
    check("recal_state", st, S_IDLE);
    check("recal_coarse", coarse, 2 ** (CW - 1));
    check("recal_cto", cto, 0);
    recal = 1'b0;
    tick();
    check("recal_to_chk", st, S_CHK);
    sar_reset();
  endtask

  task automatic sar_step(input bit f, input bit s);
    int prev;
    prev = m_code;
    sar_decide(f, s);
    do_check(f, s);
    check("sar_code", coarse, m_code);
    check("sar_state", st, m_done ? S_FINE : S_SETTLE);
    check("sar_dco", dco, (m_code != prev) ? 1 : 0);
  endtask

  task automatic wait_state(input string name, input int exp, input int max_cyc);
    int n;
    n = 0;
    while (st != exp[1:0] && n < max_cyc) begin
      tick();
      n++;
    end
    check(name, st, exp);
  endtask

  // ---------------- fine loop reference model ----------------
  int m_integ, m_fine, m_zr, m_nr;
  bit m_lock;
  bit [1:0] pipe_q[$];

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int floor_div(input int a, input int b);
    return (a >= 0) ? a / b : -((-a + b - 1) / b);
  endfunction

  task automatic fine_iter(input bit u, input bit d);
    bit [1:0] v;
    int e, prev;
    up = u; down = d;
    pipe_q.push_back({u, d});
    tick();
    v = pipe_q.pop_front();
    e = int'(v[1]) - int'(v[0]);
    prev    = m_fine;
    m_integ = clamp(m_integ + e * KI, -(2 ** (IW - 1)), 2 ** (IW - 1) - 1);
    m_fine  = clamp(2 ** (FW - 1) + floor_div(m_integ, 2 ** FRAC) + e * KP, 0, 2 ** FW - 1);
    if (e == 0) begin m_zr++; m_nr = 0; end
    else        begin m_nr++; m_zr = 0; end
    if (LOCK_EN && m_zr >= LOCK_CNT)   m_lock = 1'b1;
    if (LOCK_EN && m_nr >= UNLOCK_CNT) m_lock = 1'b0;
    check("fine_code", fine, m_fine);
    check("fine_dco", dco, (m_fine != prev) ? 1 : 0);
    check("fine_lock", lock, m_lock);
  endtask

  typedef struct {
    bit f;
    bit s;
    int exp_code;
    int exp_state;
  } sar_vec_t;

  sar_vec_t vecs[4];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 12, S_SETTLE};
    vecs[1] = '{1'b0, 1'b1, 10, S_SETTLE};
    vecs[2] = '{1'b1, 1'b0, 11, S_SETTLE};
    vecs[3] = '{1'b1, 1'b0, 11, S_FINE};

    rst = 1'b1; recal = 1'b0; up = 1'b0; down = 1'b0;
    faster = 1'b0; slower = 1'b0; fchk = 1'b0; cdone = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_coarse", coarse, 8);
    check("rst_fine", fine, 32);
    check("rst_state", st, S_IDLE);
    check("rst_dco", dco, 0);
    check("rst_lock", lock, 0);
    check("rst_cto", cto, 0);
    check("rst_def_coarse", d_coarse, 8'h80);
    check("rst_def_fine", d_fine, 8'h80);
    check("rst_def_state", d_st, S_IDLE);
    check("rst_def_dco", d_dco, 0);
    check("rst_def_lock", d_lock, 0);

    rst = 1'b0;
    tick();
    check("idle_to_chk", st, S_CHK);

    // Table-driven SAR walk: 8 -> 12 -> 10 -> 11 -> 11
    for (int i = 0; i < 4; i++) begin
      do_check(vecs[i].f, vecs[i].s);
      check($sformatf("tbl_code%0d", i), coarse, vecs[i].exp_code);
      check($sformatf("tbl_state%0d", i), st, vecs[i].exp_state);
      if (vecs[i].exp_state == S_SETTLE) begin
        do_settle();
        check($sformatf("tbl_settle%0d", i), st, S_CHK);
      end
    end

    // Inconclusive first check: code kept, straight to FINE
    do_recal();
    sar_step(1'b0, 1'b0);

    // Check strobe during C_SETTLE is ignored; recal mid-SAR
    do_recal();
    sar_step(1'b1, 1'b0);
    do_check(1'b0, 1'b1);
    check("settle_ign_code", coarse, 12);
    check("settle_ign_state", st, S_SETTLE);
    check("settle_ign_dco", dco, 0);
    recal = 1'b1;
    tick();
    check("midsar_recal_code", coarse, 8);
    check("midsar_recal_state", st, S_IDLE);
    recal = 1'b0;
    tick();
    sar_reset();

    // Timeout waiting for a check edge
    for (int i = 0; i < TIMEOUT - 2; i++) tick();
    check("to_early_state", st, S_CHK);
    check("to_early_cto", cto, 0);
    wait_state("to_chk_state", S_FINE, 6);
    check("to_chk_cto", cto, 1);
    check("to_chk_code", coarse, 8);

    // Timeout waiting for a settle edge (recal also clears the sticky flag)
    do_recal();
    sar_step(1'b1, 1'b0);
    wait_state("to_settle_state", S_FINE, TIMEOUT + 6);
    check("to_settle_cto", cto, 1);
    check("to_settle_code", coarse, 12);

    // Randomized SAR runs against the model
    for (int run = 0; run < 8; run++) begin
      do_recal();
      while (!m_done) begin
        int r;
        bit f, s;
        r = $urandom_range(0, 9);
        if (r == 0)      begin f = 1'b0; s = 1'b0; end
        else if (r == 1) begin f = 1'b1; s = 1'b1; end
        else             begin f = 1'($urandom); s = ~f; end
        sar_step(f, s);
        if (!m_done) begin
          do_settle();
          check("rnd_settle", st, S_CHK);
        end
      end
    end

    // Fine loop
    up = 1'b0; down = 1'b0;
    do_recal();
    sar_step(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    m_integ = 0; m_fine = 32; m_zr = 20; m_nr = 0;
    m_lock = LOCK_EN;
    check("fine_entry_lock", lock, m_lock);
    pipe_q.delete();
    pipe_q.push_back(2'b00);
    pipe_q.push_back(2'b00);

    // Two of the six driven samples are still inside the synchronizer.
    for (int i = 0; i < 6; i++) fine_iter(1'b1, 1'b0);
    check("fine_up4", fine, 35);
    for (int i = 0; i < 500; i++) fine_iter(1'b1, 1'b0);
    check("fine_sat_hi", fine, 63);
    for (int i = 0; i < 800; i++) fine_iter(1'b0, 1'b1);
    check("fine_sat_lo", fine, 0);
    for (int i = 0; i < 22; i++) fine_iter(1'b0, 1'b0);
    check("lock_on", lock, LOCK_EN);
    for (int i = 0; i < 6; i++) fine_iter(1'b1, 1'b0);
    check("lock_off", lock, 0);
    for (int i = 0; i < 300; i++) fine_iter(1'($urandom), 1'($urandom));
    check("fine_state", st, S_FINE);
    check("fine_coarse", coarse, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
